cpu_core_p: RTL

Parametrised successor to the bus-based CPU top. It is a multi-cycle X/Y accumulator core with generic data width (WIDTH) and address width (ADDR_W). On-chip memory is replaced by an external req/ack memory port that tolerates any number of wait states. Flags and conditional jumps keep the existing C/Z/LT semantics. It is the core instantiated beneath system tops that own memory and I/O.

---
 rtl/cpu_core_p.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/cpu_core_p.sv
// cpu_core_p: multi-cycle X/Y accumulator core with a req/ack memory port.
// The FSM runs FETCH -> DECODE -> (OPERAND -> (MEM)) -> FETCH; each access waits for mem_ack.
module cpu_core_p #(
  parameter int                WIDTH    = 16,
  parameter int                ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WIDTH-1:0]  mem_wdata,
  input  logic [WIDTH-1:0]  mem_rdata,
  input  logic              mem_ack,
  output logic              halted,
  output logic [ADDR_W-1:0] pc_out,
  output logic [WIDTH-1:0]  x_out
);

  localparam logic [2:0] S_FETCH   = 3'd0;
  localparam logic [2:0] S_DECODE  = 3'd1;
  localparam logic [2:0] S_OPERAND = 3'd2;
  localparam logic [2:0] S_MEM     = 3'd3;
  localparam logic [2:0] S_HALT    = 3'd4;

  localparam logic [3:0] OP_LDX  = 4'h1;
  localparam logic [3:0] OP_LDY  = 4'h2;
  localparam logic [3:0] OP_ADD  = 4'h3;
  localparam logic [3:0] OP_SUB  = 4'h4;
  localparam logic [3:0] OP_AND  = 4'h5;
  localparam logic [3:0] OP_LD   = 4'h6;
  localparam logic [3:0] OP_ST   = 4'h7;
  localparam logic [3:0] OP_JMP  = 4'h8;
  localparam logic [3:0] OP_JZ   = 4'h9;
  localparam logic [3:0] OP_JC   = 4'hA;
  localparam logic [3:0] OP_JLT  = 4'hB;
  localparam logic [3:0] OP_JGT  = 4'hC;
  localparam logic [3:0] OP_SWAP = 4'hD;
  localparam logic [3:0] OP_HLT  = 4'hF;

  logic [2:0]        r_state;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_opr;
  logic [3:0]        r_op;
  logic [WIDTH-1:0]  r_x;
  logic [WIDTH-1:0]  r_y;
  logic              r_c;
  logic              r_z;
  logic              r_lt;

  logic [WIDTH:0]    w_alu;
  logic [WIDTH-1:0]  w_res;
  logic [ADDR_W-1:0] w_pc_inc;
  logic [ADDR_W-1:0] w_rd_addr;
  logic              w_taken;
  logic              w_access;

  // Returns {carry, result}; AND yields carry 0.
  function automatic logic [WIDTH:0] alu_op(input logic [3:0] op,
                                            input logic [WIDTH-1:0] a,
                                            input logic [WIDTH-1:0] b);
    logic [WIDTH:0] sum;
    case (op)
      OP_ADD:  sum = {1'b0, a} + {1'b0, b};
      OP_SUB:  sum = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
      default: sum = {1'b0, a & b};
    endcase
    return sum;
  endfunction

  function automatic logic jump_taken(input logic [3:0] op, input logic c,
                                      input logic z, input logic lt);
    logic t;
    case (op)
      OP_JMP:  t = 1'b1;
      OP_JZ:   t = z;
      OP_JC:   t = c;
      OP_JLT:  t = lt;
      OP_JGT:  t = ~z & ~lt;
      default: t = 1'b0;
    endcase
    return t;
  endfunction

  assign w_alu     = alu_op(r_op, r_x, r_y);
  assign w_res     = w_alu[WIDTH-1:0];
  assign w_taken   = jump_taken(r_op, r_c, r_z, r_lt);
  assign w_pc_inc  = r_pc + {{(ADDR_W-1){1'b0}}, 1'b1};
  assign w_rd_addr = mem_rdata[ADDR_W-1:0];
  assign w_access  = (r_state == S_FETCH) || (r_state == S_OPERAND) || (r_state == S_MEM);

  // Request is gated by reset so an in-flight access is dropped the moment reset rises.
  assign mem_req   = w_access & ~reset;
  assign mem_we    = (r_state == S_MEM) && (r_op == OP_ST);
  assign mem_addr  = (r_state == S_MEM) ? r_opr : r_pc;
  assign mem_wdata = r_x;
  assign halted    = (r_state == S_HALT);
  assign pc_out    = r_pc;
  assign x_out     = r_x;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_FETCH;
      r_pc    <= RESET_PC;
      r_op    <= 4'h0;
      r_opr   <= '0;
      r_x     <= '0;
      r_y     <= '0;
      r_c     <= 1'b0;
      r_z     <= 1'b0;
      r_lt    <= 1'b0;
    end else begin
      case (r_state)
        S_FETCH: begin
          if (mem_ack) begin
            r_op    <= mem_rdata[WIDTH-1 -: 4];
            r_pc    <= w_pc_inc;
            r_state <= S_DECODE;
          end
        end
        S_DECODE: begin
          case (r_op)
            OP_ADD, OP_SUB, OP_AND: begin
              r_x     <= w_res;
              r_c     <= w_alu[WIDTH];
              r_z     <= (w_res == '0);
              r_lt    <= w_res[WIDTH-1];
              r_state <= S_FETCH;
            end
            OP_SWAP: begin
              r_x     <= r_y;
              r_y     <= r_x;
              r_state <= S_FETCH;
            end
            OP_HLT: r_state <= S_HALT;
            OP_LDX, OP_LDY, OP_LD, OP_ST,
            OP_JMP, OP_JZ, OP_JC, OP_JLT, OP_JGT: r_state <= S_OPERAND;
            default: r_state <= S_FETCH;
          endcase
        end
        S_OPERAND: begin
          if (mem_ack) begin
            r_pc <= w_pc_inc;
            case (r_op)
              OP_LDX: begin
                r_x     <= mem_rdata;
                r_state <= S_FETCH;
              end
              OP_LDY: begin
                r_y     <= mem_rdata;
                r_state <= S_FETCH;
              end
              OP_LD, OP_ST: begin
                r_opr   <= w_rd_addr;
                r_state <= S_MEM;
              end
              default: begin
                if (w_taken) r_pc <= w_rd_addr;
                r_state <= S_FETCH;
              end
            endcase
          end
        end
        S_MEM: begin
          if (mem_ack) begin
            if (r_op == OP_LD) r_x <= mem_rdata;
            r_state <= S_FETCH;
          end
        end
        S_HALT:  r_state <= S_HALT;
        default: r_state <= S_FETCH;
      endcase
    end
  end

endmodule
